psum_link_fifo: RTL and testbench

- First-word-fall-through synchronous FIFO carrying partial sums between vertically adjacent PEs.
- Upstream PE drives `push_opsum` / `opsum_pixel` and reads `opsum_fifo_full`.
- Downstream PE drives `pop_ipsum`, reads `ipsum_pixel` combinationally, and stalls on `ipsum_fifo_empty`.
- Adds occupancy reporting, almost-full early warning, sticky overflow/underflow error flags and a synchronous flush.

---
 rtl/pe_pkg.sv | 12 +
 rtl/wrap_ptr.sv | 38 +++
 rtl/psum_link_fifo.sv | 144 ++++++++++++++
 tb/tb_psum_link_fifo.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared PE-array definitions.
// Holds the default psum pixel width, the default psum link FIFO geometry
// and the psum pixel type used between vertically adjacent PEs.
package pe_pkg;

  localparam int PE_DATA_WIDTH      = 16;  // psum pixel width of a PE
  localparam int PSUM_FIFO_DEPTH    = 8;   // default psum link FIFO depth
  localparam int PSUM_FIFO_AF_LEVEL = 6;   // default almost-full threshold

  typedef logic [PE_DATA_WIDTH-1:0] psum_t;

endpackage

// File: rtl/wrap_ptr.sv
// Modulo-DEPTH pointer register.
// Counts 0..DEPTH-1 and wraps by explicit compare, so DEPTH need not be a
// power of two.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (pointer -> 0)
//   clr_i  synchronous clear (pointer -> 0), lower priority than reset
//   en_i   advance the pointer by one
//   ptr_o  current pointer value
module wrap_ptr #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)
      ptr_d = '0;
    else if (en_i)
      ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/psum_link_fifo.sv
// First-word-fall-through psum FIFO between vertically adjacent PEs.
// Upstream PE pushes partial sums, downstream PE reads the head word
// combinationally on dout and acknowledges it with pop.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   flush                synchronous clear of contents (error flags kept)
//   push, din            write request / data from upstream PE
//   full, almost_full    no free entry / count >= AF_LEVEL
//   pop                  read acknowledge from downstream PE
//   dout, empty          head word (valid when !empty) / no stored entry
//   count                registered occupancy
//   overflow, underflow  sticky error flags, cleared by clear_err
//   high_water,clear_hwm max count since reset / reload with current count
//                        (only with PSUM_LINK_FIFO_HWM_EN defined)
module psum_link_fifo
  import pe_pkg::*;
#(
  parameter  int DATA_WIDTH = PE_DATA_WIDTH,
  parameter  int DEPTH      = PSUM_FIFO_DEPTH,
  parameter  int AF_LEVEL   = PSUM_FIFO_AF_LEVEL,
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1),
  localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow,
`ifdef PSUM_LINK_FIFO_HWM_EN
  input  logic                  clear_hwm,
  output logic [CNT_WIDTH-1:0]  high_water,
`endif
  input  logic                  clear_err
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_en, rd_en, ovf_set, unf_set;

  // Status decodes come only from the registered count.
  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_WIDTH'(DEPTH));
  assign almost_full = (count_q >= CNT_WIDTH'(AF_LEVEL));

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a
  // push alongside a pop. Flush masks all traffic and error detection.
  assign wr_en   = push & (~full | pop) & ~flush;
  assign rd_en   = pop & ~empty & ~flush;
  assign ovf_set = push & full & ~pop & ~flush;
  assign unf_set = pop & empty & ~flush;

  wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk  (clk),
    .reset(reset),
    .clr_i(flush),
    .en_i (wr_en),
    .ptr_o(wr_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk  (clk),
    .reset(reset),
    .clr_i(flush),
    .en_i (rd_en),
    .ptr_o(rd_ptr)
  );

  // Storage is not reset; dout is meaningless while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= din;
  end

  assign dout = mem_q[rd_ptr];

  always_comb begin
    count_d = count_q;
    if (flush)
      count_d = '0;
    else if (wr_en && !rd_en)
      count_d = count_q + 1'b1;
    else if (!wr_en && rd_en)
      count_d = count_q - 1'b1;
  end

  // Sticky flags: a new event in the same cycle as clear_err wins.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (clear_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_set) ovf_d = 1'b1;
    if (unf_set) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

`ifdef PSUM_LINK_FIFO_HWM_EN
  // Tracks the registered count, so it follows a rise one cycle later.
  // Flush leaves it alone; only reset clears it.
  logic [CNT_WIDTH-1:0] hwm_q, hwm_d;

  always_comb begin
    hwm_d = hwm_q;
    if (clear_hwm)
      hwm_d = count_q;
    else if (count_q > hwm_q)
      hwm_d = count_q;
  end

  always_ff @(posedge clk) begin
    if (reset) hwm_q <= '0;
    else       hwm_q <= hwm_d;
  end

  assign high_water = hwm_q;
`endif

endmodule

// File: tb/tb_psum_link_fifo.sv
// Bench for psum_link_fifo: instance 0 is DEPTH=8/AF=6 (directed + random),
// instance 1 is DEPTH=6/AF=4 (random, non-power-of-two wrap). A queue-based
// model per instance predicts every output each cycle.
module tb_psum_link_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_v [2];
  logic        push_v  [2];
  logic        pop_v   [2];
  logic        clr_v   [2];
  logic        chwm_v  [2];
  logic [15:0] din_v   [2];

  logic        full0, af0, empty0, ovf0, unf0;
  logic [15:0] dout0;
  logic [3:0]  count0;
  logic        full1, af1, empty1, ovf1, unf1;
  logic [15:0] dout1;
  logic [2:0]  count1;
`ifdef PSUM_LINK_FIFO_HWM_EN
  logic [3:0]  hwm0;
  logic [2:0]  hwm1;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model
  logic [15:0] mq [2][$];
  int          m_depth [2] = '{8, 6};
  int          m_af    [2] = '{6, 4};
  bit          m_ovf [2];
  bit          m_unf [2];
  int          m_hwm [2];
  int          pushes1 = 0;

  always #5 clk = ~clk;

  psum_link_fifo #(.DATA_WIDTH(16), .DEPTH(8), .AF_LEVEL(6)) u0 (
    .clk(clk), .reset(rst), .flush(flush_v[0]), .push(push_v[0]), .din(din_v[0]),
    .full(full0), .almost_full(af0), .pop(pop_v[0]), .dout(dout0), .empty(empty0),
    .count(count0), .overflow(ovf0), .underflow(unf0),
`ifdef PSUM_LINK_FIFO_HWM_EN
    .clear_hwm(chwm_v[0]), .high_water(hwm0),
`endif
    .clear_err(clr_v[0])
  );

  psum_link_fifo #(.DATA_WIDTH(16), .DEPTH(6), .AF_LEVEL(4)) u1 (
    .clk(clk), .reset(rst), .flush(flush_v[1]), .push(push_v[1]), .din(din_v[1]),
    .full(full1), .almost_full(af1), .pop(pop_v[1]), .dout(dout1), .empty(empty1),
    .count(count1), .overflow(ovf1), .underflow(unf1),
`ifdef PSUM_LINK_FIFO_HWM_EN
    .clear_hwm(chwm_v[1]), .high_water(hwm1),
`endif
    .clear_err(clr_v[1])
  );

  task automatic chk(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs of this cycle.
  task automatic model_step(int i);
    int  n;
    bit  wr, rd, isfull, isempty;
    n = mq[i].size();
    if (rst) begin
      mq[i].delete();
      m_ovf[i] = 0; m_unf[i] = 0; m_hwm[i] = 0;
      return;
    end
    if (chwm_v[i]) m_hwm[i] = n;
    else if (n > m_hwm[i]) m_hwm[i] = n;
    if (flush_v[i]) begin
      mq[i].delete();
      if (clr_v[i]) begin m_ovf[i] = 0; m_unf[i] = 0; end
      return;
    end
    isfull  = (n == m_depth[i]);
    isempty = (n == 0);
    wr = push_v[i] && (!isfull || pop_v[i]);
    rd = pop_v[i] && !isempty;
    if (rd) void'(mq[i].pop_front());
    if (wr) mq[i].push_back(din_v[i]);
    if (clr_v[i]) begin m_ovf[i] = 0; m_unf[i] = 0; end
    if (push_v[i] && !wr) m_ovf[i] = 1;
    if (pop_v[i] && isempty) m_unf[i] = 1;
  endtask

  task automatic compare(int i);
    int unsigned c;
    logic e, f, a, ov, un;
    logic [15:0] d;
    int n;
    if (i == 0) begin
      c = count0; e = empty0; f = full0; a = af0; ov = ovf0; un = unf0; d = dout0;
    end else begin
      c = count1; e = empty1; f = full1; a = af1; ov = ovf1; un = unf1; d = dout1;
    end
    n = mq[i].size();
    chk($sformatf("u%0d.count", i), c, n);
    chk($sformatf("u%0d.empty", i), e, (n == 0));
    chk($sformatf("u%0d.full", i), f, (n == m_depth[i]));
    chk($sformatf("u%0d.almost_full", i), a, (n >= m_af[i]));
    chk($sformatf("u%0d.overflow", i), ov, m_ovf[i]);
    chk($sformatf("u%0d.underflow", i), un, m_unf[i]);
    if (n != 0) chk($sformatf("u%0d.dout", i), d, mq[i][0]);
`ifdef PSUM_LINK_FIFO_HWM_EN
    chk($sformatf("u%0d.high_water", i), (i == 0) ? int'(hwm0) : int'(hwm1), m_hwm[i]);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    if (push_v[1] && !rst && !flush_v[1]) pushes1++;
    model_step(0);
    model_step(1);
    @(negedge clk);
    compare(0);
    compare(1);
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      flush_v[i] = 0; push_v[i] = 0; pop_v[i] = 0;
      clr_v[i] = 0; chwm_v[i] = 0; din_v[i] = '0;
    end
    rst = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  task automatic push0(logic [15:0] d, logic p);
    idle();
    push_v[0] = 1; din_v[0] = d; pop_v[0] = p;
    cycle();
  endtask

  task automatic pop0();
    idle();
    pop_v[0] = 1;
    cycle();
  endtask

  initial begin
    idle();
    do_reset();
    chk("reset.count", count0, 0);
    chk("reset.empty", empty0, 1);
    chk("reset.flags", {full0, af0, ovf0, unf0}, 0);

    // Fill with 0x11..0x18
    for (int k = 0; k < 8; k++) begin
      push0(16'h0011 + 16'(k), 1'b0);
      if (k == 0) chk("lit.first_dout", dout0, 16'h0011);
      if (k == 4) chk("lit.af_at5", af0, 0);
      if (k == 5) chk("lit.af_at6", af0, 1);
    end
    chk("lit.full_after8", full0, 1);

    // Overflow: 0xBEEF dropped
    push0(16'hBEEF, 1'b0);
    chk("lit.ovf", ovf0, 1);
    chk("lit.ovf_count", count0, 8);

    // Drain in order
    for (int k = 0; k < 8; k++) begin
      chk("lit.drain_dout", dout0, 16'h0011 + 16'(k));
      pop0();
    end
    chk("lit.drained_empty", empty0, 1);
    idle(); clr_v[0] = 1; cycle();

    // Push & pop while full
    for (int k = 0; k < 8; k++) push0(16'h0011 + 16'(k), 1'b0);
    push0(16'h0100, 1'b1);
    chk("lit.pp_full_count", count0, 8);
    chk("lit.pp_full_dout", dout0, 16'h0012);
    chk("lit.pp_full_ovf", ovf0, 0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) chk("lit.wrap_last", dout0, 16'h0100);
      pop0();
    end

    // Push & pop while empty
    push0(16'h0005, 1'b1);
    chk("lit.pe_unf", unf0, 1);
    chk("lit.pe_count", count0, 1);
    chk("lit.pe_dout", dout0, 16'h0005);
    idle(); clr_v[0] = 1; cycle();
    chk("lit.clear_unf", unf0, 0);
    pop0();

    // Flush with 4 entries while pushing; underflow must survive it
    do_reset();
    pop0();
    for (int k = 0; k < 4; k++) push0(16'h0A00 + 16'(k), 1'b0);
    idle(); flush_v[0] = 1; push_v[0] = 1; din_v[0] = 16'hDEAD; cycle();
    chk("lit.flush_empty", empty0, 1);
    chk("lit.flush_count", count0, 0);
    chk("lit.flush_unf_kept", unf0, 1);
    idle(); cycle();
`ifdef PSUM_LINK_FIFO_HWM_EN
    chk("lit.flush_hwm", hwm0, 4);
`endif

    // Random traffic on both instances
    do_reset();
    for (int t = 0; t < 400; t++) begin
      idle();
      for (int i = 0; i < 2; i++) begin
        push_v[i]  = ($urandom_range(0, 9) < 6);
        pop_v[i]   = ($urandom_range(0, 9) < 5);
        din_v[i]   = 16'($urandom);
        flush_v[i] = ($urandom_range(0, 59) == 0);
        clr_v[i]   = ($urandom_range(0, 19) == 0) && !flush_v[i];
        chwm_v[i]  = ($urandom_range(0, 29) == 0);
      end
      cycle();
    end
    chk("rand.pushes1_ge20", (pushes1 >= 20), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
